// File: rtl/alu_exec_unit.sv
// EX-stage execution unit. Base RV32I ops complete in one cycle. RV32M
// multiply and divide iterate over MD_ITERS cycles, with a sign fix-up
// cycle at the end.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_CTRL,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            RESULT_VALID,
  output logic            BUSY,
  output logic            STALL,
  output logic            ILLEGAL
);

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_SUB    = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SLTU   = 5'b00110;
  localparam logic [4:0] OP_XOR    = 5'b00111;
  localparam logic [4:0] OP_SRL    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  localparam logic [5:0] LAST_ITER = 6'(MD_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t              r_state;
  logic [5:0]          r_cnt;
  logic [4:0]          r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [XLEN-1:0]     r_d;
  logic [2*XLEN-1:0]   r_p;

  logic                w_is_mul;
  logic                w_is_div;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [XLEN-1:0]     w_base;
  logic                w_ill;
  logic                w_div_special;
  logic [XLEN-1:0]     w_div_spec_res;
  logic [XLEN-1:0]     w_imm_res;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_rsh;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_fix_prod;
  logic [XLEN-1:0]     w_fix_q;
  logic [XLEN-1:0]     w_fix_r;
  logic [XLEN-1:0]     w_fix_res;

  // Magnitude of a two's-complement value; 0x80000000 maps to 2^31 unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign w_is_mul = (ALU_CTRL >= OP_MUL) && (ALU_CTRL <= OP_MULHU);
  assign w_is_div = (ALU_CTRL >= OP_DIV) && (ALU_CTRL <= OP_REMU);

  // MULHSU takes DATA1 signed and DATA2 unsigned; MUL low bits are sign-agnostic.
  assign w_a_neg = DATA1[XLEN-1] &&
                   (ALU_CTRL == OP_MUL || ALU_CTRL == OP_MULH || ALU_CTRL == OP_MULHSU ||
                    ALU_CTRL == OP_DIV || ALU_CTRL == OP_REM);
  assign w_b_neg = DATA2[XLEN-1] &&
                   (ALU_CTRL == OP_MUL || ALU_CTRL == OP_MULH ||
                    ALU_CTRL == OP_DIV || ALU_CTRL == OP_REM);
  assign w_a_mag = mag(DATA1, w_a_neg);
  assign w_b_mag = mag(DATA2, w_b_neg);

  // Single-cycle RV32I result; unknown codes give zero and flag illegal.
  always_comb begin
    w_base = '0;
    w_ill  = 1'b0;
    case (ALU_CTRL)
      OP_AND:  w_base = DATA1 & DATA2;
      OP_OR:   w_base = DATA1 | DATA2;
      OP_ADD:  w_base = DATA1 + DATA2;
      OP_SUB:  w_base = DATA1 - DATA2;
      OP_SLL:  w_base = DATA1 << DATA2[4:0];
      OP_SLT:  w_base = {{(XLEN-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
      OP_SLTU: w_base = {{(XLEN-1){1'b0}}, (DATA1 < DATA2)};
      OP_XOR:  w_base = DATA1 ^ DATA2;
      OP_SRL:  w_base = DATA1 >> DATA2[4:0];
      OP_SRA:  w_base = $unsigned($signed(DATA1) >>> DATA2[4:0]);
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_base = '0;
      default: w_ill = 1'b1;
    endcase
  end

  // Divide-by-zero and signed overflow resolve immediately without iterating.
  always_comb begin
    w_div_special  = 1'b0;
    w_div_spec_res = '0;
    if (w_is_div && DATA2 == '0) begin
      w_div_special  = 1'b1;
      w_div_spec_res = (ALU_CTRL == OP_DIV || ALU_CTRL == OP_DIVU) ? '1 : DATA1;
    end else if ((ALU_CTRL == OP_DIV || ALU_CTRL == OP_REM) &&
                 DATA1 == {1'b1, {(XLEN-1){1'b0}}} && DATA2 == '1) begin
      w_div_special  = 1'b1;
      w_div_spec_res = (ALU_CTRL == OP_DIV) ? DATA1 : '0;
    end
  end

  assign w_imm_res = w_div_special ? w_div_spec_res : w_base;

  // Shift-add step: r_p = {partial high, multiplier being shifted out}.
  assign w_mul_sum  = {1'b0, r_p[2*XLEN-1:XLEN]} + {1'b0, r_d};
  assign w_mul_next = r_p[0] ? {w_mul_sum, r_p[XLEN-1:1]}
                             : {1'b0, r_p[2*XLEN-1:XLEN], r_p[XLEN-1:1]};

  // Restoring divide step: r_p = {remainder, dividend/quotient}.
  assign w_rsh      = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
  assign w_diff     = w_rsh - {1'b0, r_d};
  assign w_div_next = w_diff[XLEN] ? {w_rsh[XLEN-1:0], r_p[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};

  // Sign fix-up and result selection for the final cycle.
  assign w_fix_prod = r_neg_q ? (~r_p + 1'b1) : r_p;
  assign w_fix_q    = r_neg_q ? (~r_p[XLEN-1:0] + 1'b1) : r_p[XLEN-1:0];
  assign w_fix_r    = r_neg_r ? (~r_p[2*XLEN-1:XLEN] + 1'b1) : r_p[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                        w_fix_res = w_fix_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_fix_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix_res = w_fix_q;
      OP_REM, OP_REMU:               w_fix_res = w_fix_r;
      default:                       w_fix_res = '0;
    endcase
  end

  assign BUSY  = (r_state != S_IDLE);
  assign STALL = BUSY | (START & (w_is_mul | w_is_div));

  // Multiply/divide datapath: latch magnitudes on accept, then iterate.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && START && !FLUSH) begin
      r_op <= ALU_CTRL;
      if (w_is_div) begin
        r_d     <= w_b_mag;
        r_p     <= {{XLEN{1'b0}}, w_a_mag};
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_d     <= w_a_mag;
        r_p     <= {{XLEN{1'b0}}, w_b_mag};
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= 1'b0;
      end
    end else if (r_state == S_MUL) begin
      r_p <= w_mul_next;
    end else if (r_state == S_DIV) begin
      r_p <= w_div_next;
    end
  end

  // Control FSM with registered result, valid and illegal outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      ILLEGAL      <= 1'b0;
    end else begin
      RESULT_VALID <= 1'b0;
      ILLEGAL      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (START && !FLUSH) begin
            if (w_is_mul) begin
              r_state <= S_MUL;
            end else if (w_is_div && !w_div_special) begin
              r_state <= S_DIV;
            end else begin
              RESULT       <= w_imm_res;
              RESULT_VALID <= 1'b1;
              ILLEGAL      <= w_ill;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (FLUSH) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!FLUSH) begin
            RESULT       <= w_fix_res;
            RESULT_VALID <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
